// File: rtl/imm_gen_pipe.sv
// RV immediate generator: decodes the instruction format from the opcode and buffers
// {imm, fmt, illegal, tag} in a 2-entry FIFO, with flush and a saturating illegal counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [2:0]       out_fmt_o,
  output logic             out_illegal_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam logic [2:0] FmtNone  = 3'd0;
  localparam logic [2:0] FmtI     = 3'd1;
  localparam logic [2:0] FmtS     = 3'd2;
  localparam logic [2:0] FmtB     = 3'd3;
  localparam logic [2:0] FmtU     = 3'd4;
  localparam logic [2:0] FmtJ     = 3'd5;
  localparam logic [2:0] FmtShamt = 3'd6;

  localparam int unsigned EntW = XLEN + 4 + TAG_W;

  logic            s;
  logic [31:0]     raw32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  logic [EntW-1:0]  entry_q [2];
  logic [EntW-1:0]  entry_d [2];
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             push, pop, widx;

  assign s = in_instr_i[31];

  // Every format is first formed as a 32-bit value that is already sign-correct.
  always_comb begin
    raw32   = '0;
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (in_instr_i[6:0])
      7'b0000011, 7'b1100111: begin
        raw32   = {{20{s}}, in_instr_i[31:20]};
        dec_fmt = FmtI;
      end
      7'b0010011: begin
        if (in_instr_i[13:12] == 2'b01) begin
          raw32   = (XLEN == 64) ? {26'b0, in_instr_i[25:20]} : {27'b0, in_instr_i[24:20]};
          dec_fmt = FmtShamt;
        end else begin
          raw32   = {{20{s}}, in_instr_i[31:20]};
          dec_fmt = FmtI;
        end
      end
      7'b0100011: begin
        raw32   = {{20{s}}, in_instr_i[31:25], in_instr_i[11:7]};
        dec_fmt = FmtS;
      end
      7'b1100011: begin
        raw32   = {{20{s}}, in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8], 1'b0};
        dec_fmt = FmtB;
      end
      7'b0110111, 7'b0010111: begin
        raw32   = {in_instr_i[31:12], 12'b0};
        dec_fmt = FmtU;
      end
      7'b1101111: begin
        raw32   = {{12{s}}, in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21], 1'b0};
        dec_fmt = FmtJ;
      end
      7'b0110011, 7'b0001111, 7'b1110011: dec_fmt = FmtNone;
      default: dec_ill = 1'b1;
    endcase
    dec_imm = XLEN'($signed(raw32));
  end

  assign in_ready_o  = (count_q != 2'd2) && !flush_i;
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  // Only a write at count 1 without a pop lands in slot 1.
  assign widx        = pop ? 1'b0 : count_q[0];

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        entry_d[0] = entry_q[1];
      end
      if (push) begin
        entry_d[widx] = {dec_imm, dec_fmt, dec_ill, in_tag_i};
        if (dec_ill && (err_q != {CNT_W{1'b1}})) begin
          err_d = err_q + 1'b1;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      count_q    <= 2'd0;
      err_q      <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_imm_o     = out_valid_o ? entry_q[0][EntW-1 -: XLEN] : '0;
  assign out_fmt_o     = out_valid_o ? entry_q[0][TAG_W+3:TAG_W+1] : '0;
  assign out_illegal_o = out_valid_o ? entry_q[0][TAG_W] : 1'b0;
  assign out_tag_o     = out_valid_o ? entry_q[0][TAG_W-1:0] : '0;
  assign err_count_o   = err_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RV datapath. Accepts raw instructions over a valid/ready handshake, decodes the instruction format from the opcode, and produces the sign- or zero-extended immediate at XLEN width. Output goes through a 2-entry output buffer so the decode stage can stall without dropping instructions. Adds U/J/JALR/shift-amount support, a passthrough tag, flush, and a saturating illegal-opcode counter.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag carried with each instruction (typically the PC).
- CNT_W, 8: width of the illegal-opcode counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the output entry.
- err_count  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode by opcode in_instr[6:0]; `s` = in_instr[31], replicated to the top of XLEN.
  - 0000011 LOAD, 1100111 JALR: I-type; imm = sext(instr[31:20]).
  - 0010011 OP-IMM with funct3 001/101: SHAMT; imm = zext(instr[24:20]) when XLEN=32, zext(instr[25:20]) when XLEN=64. instr[30] is ignored.
  - 0010011 OP-IMM, other funct3: I-type.
  - 0100011: S-type; imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: B-type; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U-type; imm = sext({instr[31:12], 12'b0}).
  - 1101111: J-type; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011, 0001111, 1110011: NONE; imm = 0; legal.
  - Any other opcode, including instr[1:0] != 11: NONE; imm = 0; out_illegal = 1.
- Decode is combinational into a 2-entry FIFO holding {imm, fmt, illegal, tag}. Entry count is 0, 1 or 2.
- in_ready = (count < 2) && !flush.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- out_valid = (count != 0). The out_* fields show the oldest entry.
- err_count increments on every push with illegal = 1. It saturates at all-ones and is cleared only by rst.

## Timing
- Latency: an instruction pushed at edge N appears on the outputs after edge N, i.e. out_valid is high in the cycle following acceptance. There is no combinational in→out path.
- Throughput: 1 instruction per cycle while out_ready is held high.
- Push and pop in the same cycle: count is unchanged and order is preserved. This is allowed at count 1 only, because count 2 forces in_ready low.
- Full (count 2): in_ready = 0. in_instr is ignored until a pop occurs, and in_ready rises in the cycle after the pop edge.
- Empty (count 0): out_valid = 0. out_imm, out_fmt, out_illegal and out_tag are 0.
- flush: count becomes 0 at the next edge, any pop in that cycle is ignored, and no push occurs (in_ready is 0). err_count is kept.
- rst: same effect as flush, and also clears err_count. Reset values: out_valid 0, in_ready 1 (after the reset cycle), out_imm 0, out_fmt 0, out_illegal 0, out_tag 0, err_count 0. Reset takes priority over flush and over all handshakes.
- Consumer contract: out_* must stay stable while out_valid && !out_ready.

## Test plan
- Formats at XLEN=32, out_ready held high, back-to-back inputs:
  - 0xFFF00093 → 0xFFFFFFFF, fmt 1.
  - 0xFE20AE23 → 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 → 0xFFFFFFF8, fmt 3.
  - 0x001000EF → 0x00000800, fmt 5.
  - Each output appears one cycle after its input, with out_tag matching in_tag.
- LUI 0x800000B7 → 0x80000000 at XLEN=32, and 0xFFFFFFFF80000000 at XLEN=64, fmt 4.
- Shifts: 0x01F09093 → 0x1F, fmt 6; 0x4030D093 → 0x3, fmt 6. At XLEN=64, 0x03F09093 → 0x3F.
- Backpressure: hold out_ready = 0 and drive 3 valid inputs.
  - in_ready falls after the 2nd accept; the 3rd input is held.
  - Raise out_ready: all 3 entries emerge in order, with no loss and no duplication.
- Illegal and NONE opcodes: inputs 0x00000033 and 0x0000007F.
  - Responses are fmt 0, imm 0, illegal 0 then 1; err_count = 1.
  - Push 300 illegal instructions with CNT_W=8: err_count saturates at 0xFF.
- Flush and reset mid-operation, starting from count = 2:
  - Assert flush together with in_valid: next cycle out_valid = 0, the input is not accepted, err_count is unchanged.
  - Repeat using rst: err_count = 0, and all outputs are at their reset values.
